// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default width.
package hilo_muldiv_unit_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage issue/result bundle between the pipeline (master) and the mul/div unit (slave).
interface hilo_muldiv_unit_if
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
);
    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit_datapath.sv
// Iterative accumulator: LSB-first shift-add multiply and restoring shift-subtract divide.
// With FAST_MULT_EN defined, a multiply loads the full product at once.
module hilo_muldiv_unit_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem
);
    logic [2*WIDTH:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_diff;

`ifdef FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, opnd_q};
        // Trial subtract of the divisor from {partial remainder, next dividend bit}
        div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
        if (load) begin
            opnd_d = is_div ? b_mag : a_mag;
            acc_d  = {{(WIDTH+1){1'b0}}, (is_div ? a_mag : b_mag)};
`ifdef FAST_MULT_EN
            if (!is_div) acc_d = {1'b0, fast_prod};
`endif
        end else if (step) begin
            if (is_div) begin
                if (!div_diff[WIDTH+1])
                    acc_d = {1'b0, div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {1'b0, acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
            end else if (acc_q[0]) begin
                acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {2'b00, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign prod = acc_q[2*WIDTH-1:0];
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage MULT/MULTU/DIV/DIVU unit owning HI/LO; FSM, sign fix-up and MTHI/MTLO writes.
// Optional FAST_MULT_EN: single-cycle multiply, RUN skipped for MULT/MULTU.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    hilo_muldiv_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(ITERS);

    md_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;
    logic             is_div_q, neg_q, rem_neg_q, bzero_q;
    logic             load, step, commit;
    logic             sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo, rem;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign sa    = !bus.op[0] && bus.a[WIDTH-1];
    assign sb    = !bus.op[0] && bus.b[WIDTH-1];
    assign a_mag = sa ? WIDTH'(0) - bus.a : bus.a;
    assign b_mag = sb ? WIDTH'(0) - bus.b : bus.b;

    hilo_muldiv_unit_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (load ? bus.op[1] : is_div_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .prod   (prod),
        .quo    (quo),
        .rem    (rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (bus.start && !bus.flush) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = MD_RUN;
`ifdef FAST_MULT_EN
                    if (!bus.op[1]) state_d = MD_FIX;
`endif
                end
            end
            MD_RUN: begin
                if (bus.flush) begin
                    state_d = MD_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(ITERS - 1)) state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                commit  = !bus.flush;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Remainder takes the dividend's sign, so a divide by zero returns the raw dividend in HI
    always_comb begin
        prod_fix = neg_q ? (2*WIDTH)'(0) - prod : prod;
        if (is_div_q) begin
            res_hi = rem_neg_q ? WIDTH'(0) - rem : rem;
            res_lo = bzero_q ? '1 : (neg_q ? WIDTH'(0) - quo : quo);
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= commit;
            if (load) begin
                is_div_q  <= bus.op[1];
                neg_q     <= sa ^ sb;
                rem_neg_q <= sa;
                bzero_q   <= (bus.b == '0);
            end
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state_q == MD_IDLE) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy = (state_q != MD_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit; expected latencies follow FAST_MULT_EN when defined.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    localparam int ITERS = 32;
`ifdef FAST_MULT_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = ITERS + 1;
`endif
    localparam int LAT_DIV = ITERS + 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   busy_c, done_c, first_done;

    hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(
        .WIDTH (32),
        .ITERS (ITERS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input md_op_e o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        tick();
        bus.start = 1'b0;
    endtask

    // Bounded observation window: busy cycles, done cycles, first done sample index
    task automatic watch(input int n, output int bc, output int dc, output int fd);
        bc = 0;
        dc = 0;
        fd = -1;
        for (int k = 0; k < n; k++) begin
            if (bus.busy) bc++;
            if (bus.done) begin
                dc++;
                if (fd < 0) fd = k;
            end
            tick();
        end
    endtask

    task automatic run_op(input string tag, input md_op_e o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input int lat);
        int bc, dc, fd;
        issue(o, x, y);
        watch(40, bc, dc, fd);
        check({tag, "_busy"}, bc, lat);
        check({tag, "_done_cnt"}, dc, 1);
        check({tag, "_done_at"}, fd, lat);
        check({tag, "_hi"}, bus.hi, eh);
        check({tag, "_lo"}, bus.lo, el);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        reset = 1'b0;
        tick();

        run_op("multu", MD_MULTU, 32'd111111, 32'd222222, 32'h0000_0005, 32'hBFB7_7862, LAT_MUL);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_MUL);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, LAT_DIV);
        run_op("divu_z", MD_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, LAT_DIV);
        run_op("div_z", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, LAT_DIV);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, LAT_DIV);

        // MTHI preload, then flush the op at RUN cycle 10
        bus.hi_we = 1'b1;
        bus.wdata = 32'hAAAA;
        tick();
        bus.hi_we = 1'b0;
        check("mthi", bus.hi, 32'hAAAA);
`ifdef FAST_MULT_EN
        issue(MD_DIV, 32'd3, 32'd4);
`else
        issue(MD_MULT, 32'd3, 32'd4);
`endif
        for (int k = 0; k < 10; k++) tick();
        check("flush_pre_busy", bus.busy, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        watch(40, busy_c, done_c, first_done);
        check("flush_no_done", done_c, 0);
        check("flush_hi", bus.hi, 32'hAAAA);
        check("flush_lo", bus.lo, 32'h8000_0000);

        // flush together with start: start dropped
        bus.flush = 1'b1;
        issue(MD_DIVU, 32'd9, 32'd3);
        bus.flush = 1'b0;
        check("flush_start_busy", bus.busy, 0);
        watch(40, busy_c, done_c, first_done);
        check("flush_start_done", done_c, 0);

        // Second start and MTHI while busy are ignored
        issue(MD_DIVU, 32'd1000, 32'd7);
        busy_c = 0;
        done_c = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy) busy_c++;
            if (bus.done) done_c++;
            if (k == 3) begin
                bus.start = 1'b1;
                bus.op    = MD_MULTU;
                bus.a     = 32'd6;
                bus.b     = 32'd7;
                bus.hi_we = 1'b1;
                bus.wdata = 32'h5555;
            end else begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
            end
            tick();
        end
        check("busy_ign_cycles", busy_c, LAT_DIV);
        check("busy_ign_done", done_c, 1);
        check("busy_ign_hi", bus.hi, 32'd6);
        check("busy_ign_lo", bus.lo, 32'd142);

        // MTLO coincident with start: write lands, then the result overwrites it
        bus.lo_we = 1'b1;
        bus.wdata = 32'h77;
        issue(MD_DIVU, 32'd100, 32'd7);
        bus.lo_we = 1'b0;
        check("mtlo_start_lo", bus.lo, 32'h77);
        check("mtlo_start_busy", bus.busy, 1);
        watch(40, busy_c, done_c, first_done);
        check("mtlo_start_res_lo", bus.lo, 32'd14);
        check("mtlo_start_res_hi", bus.hi, 32'd2);

        // Reset at RUN cycle 5
        issue(MD_DIVU, 32'd1000, 32'd7);
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        reset = 1'b0;
        watch(40, busy_c, done_c, first_done);
        check("midrst_no_done", done_c, 0);

        run_op("multu_again", MD_MULTU, 32'd111111, 32'd222222, 32'h0000_0005, 32'hBFB7_7862,
               LAT_MUL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
